// File: rtl/cel_packer.sv
// 3DO packed-cel line encoder: one pixel line in, packed 32-bit word stream out.
// Words are buffered per line so the offset in word 0 can be patched as it is sent.
module cel_packer #(
  parameter int LINE_WORDS = 256,
  parameter int MAX_RUN    = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  bpp,
  input  logic        line_start,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [15:0] pix_data,
  input  logic        pix_transp,
  input  logic        pix_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] dout,
  output logic        line_done,
  output logic        overflow,
  output logic [2:0]  fsm_state
);
  localparam int CW = $clog2(LINE_WORDS + 1);
  localparam int AW = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ACCEPT = 3'd1, S_FLUSH = 3'd2, S_FINISH = 3'd3, S_SEND = 3'd4
  } state_t;
  typedef enum logic [1:0] {
    PK_EOL = 2'b00, PK_LIT = 2'b01, PK_TRANSP = 2'b10, PK_REP = 2'b11
  } pk_t;

  state_t state, state_nx;

  logic [2:0]    bpp_q;
  logic [4:0]    fw;
  logic [15:0]   fmask;
  logic          hdr16_q;
  logic [31:0]   cur_word;
  logic [5:0]    bit_ptr;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_ptr;
  logic [31:0]   mem [LINE_WORDS];
  logic          pk_open;
  pk_t           pk_type;
  logic [6:0]    pk_cnt;
  logic [15:0]   pk_val;
  logic [15:0]   lit_buf [64];
  logic          pend_valid;
  logic          pend_transp;
  logic [15:0]   pend_val;
  logic          fin_after;
  logic [6:0]    fl_idx;
  logic          eol_done;

  // Both ports use valid/ready: a beat transfers on the rising edge where valid and
  // ready are both high; a source holds its data stable while valid && !ready.
  assign pix_ready = (state == S_ACCEPT);
  assign fsm_state = state;
  assign hdr16_q   = !(bpp_q inside {[3'd1:3'd4]});

  always_comb begin
    fw    = 5'd16;
    fmask = 16'hFFFF;
    case (bpp_q)
      3'd1: begin fw = 5'd1; fmask = 16'h0001; end
      3'd2: begin fw = 5'd2; fmask = 16'h0003; end
      3'd3: begin fw = 5'd4; fmask = 16'h000F; end
      3'd4: begin fw = 5'd6; fmask = 16'h003F; end
      3'd5: begin fw = 5'd8; fmask = 16'h00FF; end
      default: ;
    endcase
  end

  // Greedy packet policy for the pixel being accepted.
  logic        accept, ext_t, ext_r, conv, app_l, close;
  logic [15:0] pv;
  assign accept = pix_ready && pix_valid;
  assign pv     = pix_data & fmask;
  assign ext_t  = pk_open && pk_type == PK_TRANSP && pk_cnt < 7'(MAX_RUN);
  assign ext_r  = pk_open && pk_type == PK_REP && pk_val == pv && pk_cnt < 7'(MAX_RUN);
  assign conv   = pk_open && pk_type == PK_LIT && pk_cnt == 7'd1 && lit_buf[0] == pv;
  assign app_l  = pk_open && pk_type == PK_LIT && pk_cnt < 7'(MAX_RUN);
  assign close  = pix_transp ? (pk_open && !ext_t) : (pk_open && !ext_r && !conv && !app_l);

  logic fl_last, fin_word, fin_zero, fin_done;
  assign fl_last  = (pk_type == PK_TRANSP && fl_idx == 7'd0) ||
                    (pk_type == PK_REP && fl_idx == 7'd1) ||
                    (pk_type == PK_LIT && fl_idx == pk_cnt);
  assign fin_word = state == S_FINISH && eol_done && bit_ptr != 6'd0;
  assign fin_zero = state == S_FINISH && eol_done && bit_ptr == 6'd0 && wr_cnt < CW'(2);
  assign fin_done = state == S_FINISH && eol_done && bit_ptr == 6'd0 && wr_cnt >= CW'(2);

  logic        app_en;
  logic [4:0]  app_w;
  logic [15:0] app_f;
  always_comb begin
    app_en = 1'b0;
    app_w  = 5'd8;
    app_f  = 16'd0;
    if (state == S_FLUSH) begin
      app_en = 1'b1;
      if (fl_idx == 7'd0) begin
        app_f = {8'd0, pk_type, 6'(pk_cnt - 7'd1)};
      end else begin
        app_w = fw;
        app_f = (pk_type == PK_LIT) ? lit_buf[6'(fl_idx - 7'd1)] : pk_val;
      end
    end else if (state == S_FINISH && !eol_done) begin
      app_en = 1'b1;
      app_f  = {8'd0, PK_EOL, 6'd0};
    end
  end

  // Fields land MSB-first below the bit pointer; the upper half of acc is the word
  // being filled, the lower half catches whatever spills past bit 0.
  logic [6:0]  shamt, new_ptr;
  logic [63:0] acc;
  assign shamt   = 7'd64 - {1'b0, bit_ptr} - {2'b0, app_w};
  assign acc     = {cur_word, 32'd0} | ({48'd0, app_f} << shamt);
  assign new_ptr = {1'b0, bit_ptr} + {2'b0, app_w};

  logic        wr_req;
  logic [31:0] wr_word;
  always_comb begin
    wr_req  = 1'b0;
    wr_word = acc[63:32];
    if (app_en && new_ptr >= 7'd32) begin
      wr_req = 1'b1;
    end else if (fin_word) begin
      wr_req  = 1'b1;
      wr_word = cur_word;
    end else if (fin_zero) begin
      wr_req  = 1'b1;
      wr_word = 32'd0;
    end
  end

  logic        lb_we;
  logic [5:0]  lb_idx;
  logic [15:0] lb_data;
  always_comb begin
    lb_we   = 1'b0;
    lb_idx  = 6'd0;
    lb_data = pv;
    if (accept && !close && !pix_transp && !ext_r && !conv) begin
      lb_we  = 1'b1;
      lb_idx = pk_open ? pk_cnt[5:0] : 6'd0;
    end else if (state == S_FLUSH && fl_last && pend_valid && !pend_transp) begin
      lb_we   = 1'b1;
      lb_data = pend_val;
    end
  end

  always_ff @(posedge clock) begin
    if (lb_we) lit_buf[lb_idx] <= lb_data;
    if (wr_req && wr_cnt < CW'(LINE_WORDS)) mem[wr_cnt[AW-1:0]] <= wr_word;
  end

  logic [9:0]  off;
  logic [31:0] rd_word, out_word;
  assign off      = 10'(wr_cnt) - 10'd2;
  assign rd_word  = mem[rd_ptr[AW-1:0]];
  assign out_word = (rd_ptr != '0) ? rd_word :
                    hdr16_q ? {6'd0, off, rd_word[15:0]} : {off[7:0], rd_word[23:0]};

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (line_start) state_nx = S_ACCEPT;
      S_ACCEPT: if (accept && (close || pix_last)) state_nx = S_FLUSH;
      S_FLUSH:  if (fl_last) state_nx = pend_valid ? (fin_after ? S_FLUSH : S_ACCEPT) : S_FINISH;
      S_FINISH: if (fin_done) state_nx = S_SEND;
      S_SEND:   if (out_valid && out_ready && rd_ptr == wr_cnt) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bpp_q <= '0; cur_word <= '0; bit_ptr <= '0; wr_cnt <= '0; rd_ptr <= '0;
      pk_open <= 1'b0; pk_type <= PK_EOL; pk_cnt <= '0; pk_val <= '0;
      pend_valid <= 1'b0; pend_transp <= 1'b0; pend_val <= '0;
      fin_after <= 1'b0; fl_idx <= '0; eol_done <= 1'b0;
      out_valid <= 1'b0; dout <= '0; line_done <= 1'b0; overflow <= 1'b0;
    end else begin
      line_done <= 1'b0;
      if (wr_req) begin
        if (wr_cnt < CW'(LINE_WORDS)) wr_cnt <= wr_cnt + CW'(1);
        else                          overflow <= 1'b1;
      end
      if (app_en) begin
        if (new_ptr >= 7'd32) begin
          cur_word <= acc[31:0];
          bit_ptr  <= 6'(new_ptr - 7'd32);
        end else begin
          cur_word <= acc[63:32];
          bit_ptr  <= new_ptr[5:0];
        end
      end else if (fin_word) begin
        cur_word <= '0;
        bit_ptr  <= '0;
      end
      case (state)
        S_IDLE: if (line_start) begin
          bpp_q    <= bpp;
          overflow <= (bpp == 3'd0 || bpp == 3'd7);
          cur_word <= '0;
          bit_ptr  <= (bpp inside {[3'd1:3'd4]}) ? 6'd8 : 6'd16;
          wr_cnt <= '0; rd_ptr <= '0; pk_open <= 1'b0; pend_valid <= 1'b0;
          fin_after <= 1'b0; fl_idx <= '0; eol_done <= 1'b0;
        end
        S_ACCEPT: if (accept) begin
          fin_after <= pix_last;
          fl_idx    <= '0;
          if (close) begin
            pend_valid  <= 1'b1;
            pend_transp <= pix_transp;
            pend_val    <= pv;
          end else if (pix_transp) begin
            if (ext_t) pk_cnt <= pk_cnt + 7'd1;
            else begin pk_open <= 1'b1; pk_type <= PK_TRANSP; pk_cnt <= 7'd1; end
          end else if (ext_r) begin
            pk_cnt <= pk_cnt + 7'd1;
          end else if (conv) begin
            pk_type <= PK_REP; pk_cnt <= 7'd2; pk_val <= pv;
          end else if (pk_open) begin
            pk_cnt <= pk_cnt + 7'd1;
          end else begin
            pk_open <= 1'b1; pk_type <= PK_LIT; pk_cnt <= 7'd1;
          end
        end
        S_FLUSH: if (fl_last) begin
          fl_idx <= '0;
          if (pend_valid) begin
            pend_valid <= 1'b0;
            pk_open    <= 1'b1;
            pk_type    <= pend_transp ? PK_TRANSP : PK_LIT;
            pk_cnt     <= 7'd1;
            pk_val     <= pend_val;
          end else begin
            pk_open <= 1'b0;
          end
        end else begin
          fl_idx <= fl_idx + 7'd1;
        end
        S_FINISH: if (!eol_done) eol_done <= 1'b1;
        S_SEND: if (!out_valid) begin
          if (rd_ptr < wr_cnt) begin
            dout <= out_word; out_valid <= 1'b1; rd_ptr <= rd_ptr + CW'(1);
          end
        end else if (out_ready) begin
          if (rd_ptr < wr_cnt) begin
            dout <= out_word; rd_ptr <= rd_ptr + CW'(1);
          end else begin
            out_valid <= 1'b0; dout <= '0; line_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cel_packer.sv
// Directed bench for cel_packer: hand-packed reference lines, stalled output,
// reserved bpp, and a reset in the middle of a packet flush.
module tb_cel_packer;
  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  bpp;
  logic        line_start, pix_valid, pix_ready, pix_transp, pix_last;
  logic [15:0] pix_data;
  logic        out_valid, out_ready, line_done, overflow;
  logic [31:0] dout;
  logic [2:0]  fsm_state;

  cel_packer dut (
    .clock(clock), .reset(reset), .bpp(bpp), .line_start(line_start),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_transp(pix_transp), .pix_last(pix_last), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout), .line_done(line_done),
    .overflow(overflow), .fsm_state(fsm_state)
  );

  always #5 clock = ~clock;

  int          n_vec = 0;
  int          n_err = 0;
  int          ld_cnt;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [15:0] px_val [128];
  logic        px_tr  [128];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_line(input logic [2:0] b);
    @(posedge clock); #1;
    bpp = b;
    line_start = 1'b1;
    @(posedge clock); #1;
    line_start = 1'b0;
  endtask

  task automatic drive_pixels(input int n, input bit with_last);
    int wait_cyc;
    for (int i = 0; i < n; i++) begin
      pix_valid  = 1'b1;
      pix_data   = px_val[i];
      pix_transp = px_tr[i];
      pix_last   = with_last && (i == n - 1);
      wait_cyc   = 0;
      @(negedge clock);
      while (!pix_ready && wait_cyc < 300) begin
        @(negedge clock);
        wait_cyc++;
      end
      if (!pix_ready) begin
        check("pix_ready_timeout", {31'd0, pix_ready}, 32'd1);
        break;
      end
      @(posedge clock); #1;
    end
    pix_valid = 1'b0; pix_last = 1'b0; pix_transp = 1'b0; pix_data = '0;
  endtask

  task automatic collect(input bit toggle, input int budget);
    logic [31:0] held;
    bit          stalled;
    int          cyc;
    int          tail;
    got_q.delete();
    ld_cnt  = 0;
    stalled = 1'b0;
    held    = '0;
    cyc     = 0;
    tail    = -1;
    while (cyc < budget && tail != 0) begin
      @(negedge clock);
      cyc++;
      if (stalled) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_dout", dout, held);
      end
      out_ready = toggle ? ~out_ready : 1'b1;
      if (line_done) ld_cnt++;
      if (out_valid && out_ready) got_q.push_back(dout);
      stalled = out_valid && !out_ready;
      held    = dout;
      if (tail > 0) tail--;
      else if (ld_cnt > 0) tail = 4;
    end
    out_ready = 1'b0;
  endtask

  task automatic compare_words(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_line_done"}, 32'(ld_cnt), 32'd1);
  endtask

  task automatic load_556();
    px_val[0] = 16'h0005; px_tr[0] = 1'b0;
    px_val[1] = 16'h0005; px_tr[1] = 1'b0;
    px_val[2] = 16'h0006; px_tr[2] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; bpp = '0; line_start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    pix_transp = 1'b0; pix_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_dout", dout, 32'd0);
    check("rst_line_done", {31'd0, line_done}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
    check("rst_state", {29'd0, fsm_state}, 32'd0);

    // 8bpp literal of three
    px_val[0] = 16'h0011; px_tr[0] = 1'b0;
    px_val[1] = 16'h0022; px_tr[1] = 1'b0;
    px_val[2] = 16'h0033; px_tr[2] = 1'b0;
    start_line(3'd5);
    drive_pixels(3, 1'b1);
    exp_q = '{32'h0000_4211, 32'h2233_0000};
    collect(1'b0, 400);
    compare_words("lit3");
    check("lit3_overflow", {31'd0, overflow}, 32'd0);

    // 4bpp transparent run then one opaque pixel with junk above the low nibble
    for (int i = 0; i < 5; i++) begin px_val[i] = 16'hFFFF; px_tr[i] = 1'b1; end
    px_val[5] = 16'hFFF7; px_tr[5] = 1'b0;
    start_line(3'd3);
    drive_pixels(6, 1'b1);
    exp_q = '{32'h0084_4070, 32'h0000_0000};
    collect(1'b0, 400);
    compare_words("transp");

    // 16bpp run of 70 splits at 64; output stalled every other cycle
    for (int i = 0; i < 70; i++) begin px_val[i] = 16'hABCD; px_tr[i] = 1'b0; end
    start_line(3'd6);
    drive_pixels(70, 1'b1);
    exp_q = '{32'h0001_FFAB, 32'hCDC5_ABCD, 32'h0000_0000};
    collect(1'b1, 600);
    compare_words("rep70");

    // 8bpp one-pixel literal converts to repeat
    load_556();
    start_line(3'd5);
    drive_pixels(3, 1'b1);
    exp_q = '{32'h0000_C105, 32'h4006_0000};
    collect(1'b0, 400);
    compare_words("conv");

    // 6bpp literal whose third pixel straddles the word boundary
    px_val[0] = 16'h003F; px_tr[0] = 1'b0;
    px_val[1] = 16'h0001; px_tr[1] = 1'b0;
    px_val[2] = 16'h002A; px_tr[2] = 1'b0;
    px_val[3] = 16'h0015; px_tr[3] = 1'b0;
    start_line(3'd4);
    drive_pixels(4, 1'b1);
    exp_q = '{32'h0043_FC1A, 32'h9500_0000};
    collect(1'b0, 400);
    compare_words("bpp6");

    // reserved bpp packs as 16bpp and flags overflow
    px_val[0] = 16'h1234; px_tr[0] = 1'b0;
    start_line(3'd0);
    drive_pixels(1, 1'b1);
    exp_q = '{32'h0000_4012, 32'h3400_0000};
    collect(1'b0, 400);
    compare_words("rsvd");
    check("rsvd_overflow", {31'd0, overflow}, 32'd1);

    // reset while a packet is being flushed, then the same line again
    load_556();
    start_line(3'd5);
    drive_pixels(3, 1'b0);
    @(negedge clock);
    check("mid_state_flush", {29'd0, fsm_state}, 32'd2);
    check("mid_overflow_clr", {31'd0, overflow}, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_dout", dout, 32'd0);
    check("mid_rst_line_done", {31'd0, line_done}, 32'd0);
    check("mid_rst_state", {29'd0, fsm_state}, 32'd0);
    load_556();
    start_line(3'd5);
    drive_pixels(3, 1'b1);
    exp_q = '{32'h0000_C105, 32'h4006_0000};
    collect(1'b0, 400);
    compare_words("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cel_packer.md
Name: cel_packer

Overview:
- Encoder for the 3DO packed-cel line format. It is the write-side counterpart of the packed-cel unpacker.
- Accepts one cel line as a pixel stream and produces the packed 32-bit word stream: line offset, packets (LITERAL/TRANSP/REPEAT), EOL, then padding.
- Sits between a pixel source (test pattern or cel-builder DMA) and a memory writer that stores words at incrementing addresses.

Parameters:
- LINE_WORDS, 256, depth of the internal output word buffer, which is the maximum packed words per line.
- MAX_RUN, 64, maximum pixels per packet; fixed by the 6-bit count field (count = pixels-1).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- bpp  input  3  1=1bpp, 2=2bpp, 3=4bpp, 4=6bpp, 5=8bpp, 6=16bpp; 0 and 7 reserved. Sampled at line_start.
- line_start  input  1  pulse; begins a new line. Ignored unless idle.
- pix_valid  input  1  pixel present
- pix_ready  output  1  packer accepts the pixel this cycle
- pix_data  input  16  pixel value; only the low bpp bits are used
- pix_transp  input  1  pixel is transparent; pix_data is ignored
- pix_last  input  1  final pixel of the line; qualified by pix_valid&pix_ready
- out_valid  output  1  dout holds a packed word
- out_ready  input  1  downstream takes dout
- dout  output  32  packed word
- line_done  output  1  one-cycle pulse after the last word of the line is taken
- overflow  output  1  sticky; the line exceeded LINE_WORDS. Cleared by reset or line_start.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, buffers and counters cleared. Reset mid-line discards the line; nothing further is emitted.
- Bit order: fields are appended MSB-first into the current 32-bit word. A full word is written to the buffer and the bit pointer wraps to 0. The unpacker shifts left from bit 31 and reads this order directly.
- Line header: a reserved offset field, 8 bits for bpp 1–4 and 16 bits for bpp 5–6. For bpp 5–6 the field is 6 zero pad bits followed by a 10-bit offset.
- Packet header: 8 bits, {type[1:0], count[5:0]}. Types: EOL=00, LITERAL=01, TRANSP=10, REPEAT=11.
- Packet bodies:
  - LITERAL: count+1 pixel fields.
  - REPEAT: one pixel field.
  - TRANSP: no body.
  - Pixel field width is 1/2/4/6/8/16 bits per bpp.
- Encoding policy (greedy, deterministic), applied per accepted pixel:
  - Transparent pixel: extends an open TRANSP packet if it holds fewer than MAX_RUN pixels; otherwise the open packet is closed and a new TRANSP packet opens.
  - Opaque pixel, open REPEAT with the same value and fewer than MAX_RUN pixels: extend the REPEAT.
  - Opaque pixel, open LITERAL of exactly one pixel with the same value: convert it to REPEAT with 2 pixels.
  - Opaque pixel, any other open LITERAL with fewer than MAX_RUN pixels: append to the LITERAL.
  - Otherwise: close the open packet and open a LITERAL with 1 pixel.
  - Value comparison uses only the low bpp bits.
- Closing a packet:
  - pix_ready goes low.
  - The header is emitted in 1 cycle, then body fields at 1 per cycle from the 64-entry literal holding buffer.
  - pix_ready returns high the cycle after the last field.
- pix_last: after the pixel is applied, the open packet is closed and EOL header 0x00 is appended. The current word is zero-padded to 32 bits. Zero words are then appended until the total is at least 2 words.
- Offset: equals total words − 2 and is patched into the high bits of word 0. For bpp 1–4 the offset is truncated to 8 bits; for bpp 5–6 it is 10 bits.
- FSM:
  - IDLE → ACCEPT on line_start.
  - ACCEPT ↔ FLUSH on a packet close.
  - ACCEPT → FLUSH → FINISH on pix_last.
  - FINISH → SEND once padding is done.
  - SEND → IDLE after the final handshake. line_done pulses the next cycle.
- SEND:
  - Words are presented in buffer order.
  - dout and out_valid hold until out_valid&out_ready.
  - First out_valid occurs 1 cycle after entering SEND. Thereafter one word per cycle while out_ready is high.
- Overflow: if a write would exceed LINE_WORDS, overflow is set, further words are dropped, and the FSM still completes SEND of the stored words.
- Reserved bpp values: treated as 16bpp widths with overflow set.
- line_start outside IDLE is ignored.

Test Plan:
- 8bpp, 3 opaque pixels 0x11,0x22,0x33 with last on the third → 2 words: 0x0000_4211, 0x2233_0000 (offset 0, header 0x42, EOL 0x00, pad).
- 4bpp, 5 transparent pixels then last opaque 0x7 → word 0 = 0x0084_4070: offset 0x00, TRANSP header 0x84, LITERAL header 0x40, pixel 0x7 in bits 15:12, EOL 0x00 in bits 11:4, bits 3:0 zero; word 1 = 0; total 2 words.
- 16bpp, 70 identical pixels 0xABCD → REPEAT count 63 (header 0xFF) then REPEAT count 5 (header 0xC5), each followed by 0xABCD; total words match and offset = words−2.
- 8bpp, pixels 5,5,6 → REPEAT (0xC1, 0x05) then LITERAL (0x40, 0x06); checks the one-pixel LITERAL→REPEAT conversion.
- out_ready toggled every other cycle during SEND → no word lost or duplicated, dout stable while stalled, line_done pulses exactly once.
- Reset asserted mid-FLUSH, then a fresh line → all outputs 0 after reset; the second line packs identically to a reference run.
